// File: rtl/packet_consumer_mc.sv
// packet_consumer_mc
// Multi-VC packet sink for a NoC endpoint. Phits are assembled into flits per
// VC. A small per-VC FSM extracts the source address, counts flits and computes
// time of flight from the injection stamp carried in the second flit. Completed
// packet records go into a first-word-fall-through FIFO that the traffic
// monitor drains with a valid/ready handshake.
//
// Ports:
//   clk, rs (async, active-low)   clock and reset
//   en                            phit acceptance enable (FIFO drains regardless)
//   in_new/in_vc/indata/in_tail   phit input
//   timer                         free-running global time
//   out_valid/out_ready           record handshake
//   out_vc/out_source_addr/out_packet_length/out_time_of_flight  head record
//   drop_count                    records lost to a full FIFO (saturating)
//
// Optional build macro PACKET_CONSUMER_STATS_EN adds pkt_count (wrapping count
// of emitted records, dropped ones included) and tof_max (running maximum tof).
module packet_consumer_mc #(
  parameter int flit_size                   = 1,
  parameter int floorplusone_log2_flit_size = 1,
  parameter int phit_size                   = 32,
  parameter int num_vc                      = 4,
  parameter int vc_bits                     = 2,
  parameter int addr_length                 = 8,
  parameter int addr_place_in_header        = 0,
  parameter int ts_width                    = 64,
  parameter int fifo_depth                  = 4,
  parameter int fifo_ptr_bits               = 2
) (
  input  logic                   clk,
  input  logic                   rs,
  input  logic                   en,
  input  logic                   in_new,
  input  logic [vc_bits-1:0]     in_vc,
  input  logic [phit_size-1:0]   indata,
  input  logic                   in_tail,
  input  logic [ts_width-1:0]    timer,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [vc_bits-1:0]     out_vc,
  output logic [addr_length-1:0] out_source_addr,
  output logic [15:0]            out_packet_length,
  output logic [31:0]            out_time_of_flight,
`ifdef PACKET_CONSUMER_STATS_EN
  output logic [31:0]            pkt_count,
  output logic [31:0]            tof_max,
`endif
  output logic [15:0]            drop_count
);

  localparam int FW  = flit_size * phit_size;
  localparam int SW  = (ts_width < FW) ? ts_width : FW;
  localparam int CW  = floorplusone_log2_flit_size;
  localparam int QW  = fifo_ptr_bits + 1;
  localparam int SRC = addr_length + addr_place_in_header;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Differences that do not fit in 32 bits (including "stamp after land",
  // which wraps to a huge value) saturate to all-ones.
  function automatic logic [31:0] sat_tof(input logic [ts_width-1:0] d);
    return ((d >> 32) != '0) ? 32'hFFFF_FFFF : 32'(d);
  endfunction

  // Per-VC state
  logic [CW-1:0]          phit_cnt [num_vc];
  logic [1:0]             state    [num_vc];
  logic [FW-1:0]          flit_buf [num_vc];
  logic [addr_length-1:0] src_r    [num_vc];
  logic [ts_width-1:0]    land_r   [num_vc];
  logic [15:0]            len_r    [num_vc];
  logic [31:0]            tof_r    [num_vc];

  // Record FIFO
  logic [vc_bits-1:0]       q_vc  [fifo_depth];
  logic [addr_length-1:0]   q_src [fifo_depth];
  logic [15:0]              q_len [fifo_depth];
  logic [31:0]              q_tof [fifo_depth];
  logic [fifo_ptr_bits-1:0] wr_ptr, rd_ptr;
  logic [QW-1:0]            q_cnt;

  logic                   accept, last_phit, flit_done, tail_vld;
  logic [FW-1:0]          flit_c;
  logic [ts_width-1:0]    stamp_c;
  logic [31:0]            head_tof;
  logic                   emit;
  logic [addr_length-1:0] rec_src;
  logic [15:0]            rec_len;
  logic [31:0]            rec_tof;
  logic                   full, pop, push, drop;

  // Input stage: phit acceptance and flit completion
  assign accept    = en & in_new & (int'(in_vc) < num_vc);
  assign last_phit = (int'(phit_cnt[in_vc]) == flit_size - 1);
  assign flit_done = accept & last_phit;
  assign tail_vld  = flit_done & in_tail;

  // The completed flit is the buffered earlier phits with the current phit
  // merged in, so the FSM acts on the same edge the last phit arrives.
  always_comb begin
    flit_c = flit_buf[in_vc];
    flit_c[int'(phit_cnt[in_vc]) * phit_size +: phit_size] = indata;
    stamp_c = '0;
    stamp_c[SW-1:0] = flit_c[SW-1:0];
    head_tof = sat_tof(land_r[in_vc] - stamp_c);
  end

  always_comb begin
    emit    = 1'b0;
    rec_src = src_r[in_vc];
    rec_len = len_r[in_vc];
    rec_tof = tof_r[in_vc];
    case (state[in_vc])
      S_IDLE: begin
        emit    = tail_vld;
        rec_src = flit_c[SRC +: addr_length];
        rec_len = 16'd1;
        rec_tof = 32'd0;
      end
      S_HEAD: begin
        emit    = tail_vld;
        rec_len = 16'd2;
        rec_tof = head_tof;
      end
      S_BODY: begin
        emit    = tail_vld;
        rec_len = sat_inc16(len_r[in_vc]);
      end
      default: emit = 1'b0;
    endcase
  end

  // Output stage: FIFO handshake
  assign full = (q_cnt == QW'(fifo_depth));
  assign pop  = out_valid & out_ready;
  assign push = emit & (~full | pop);
  assign drop = emit & full & ~pop;

  assign out_valid          = (q_cnt != '0);
  assign out_vc             = out_valid ? q_vc[rd_ptr]  : '0;
  assign out_source_addr    = out_valid ? q_src[rd_ptr] : '0;
  assign out_packet_length  = out_valid ? q_len[rd_ptr] : '0;
  assign out_time_of_flight = out_valid ? q_tof[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int i = 0; i < num_vc; i++) begin
        phit_cnt[i] <= '0;
        state[i]    <= S_IDLE;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_cnt      <= '0;
      drop_count <= '0;
    end else begin
      if (accept)
        phit_cnt[in_vc] <= last_phit ? '0 : phit_cnt[in_vc] + CW'(1);
      if (flit_done) begin
        case (state[in_vc])
          S_IDLE:  state[in_vc] <= in_tail ? S_IDLE : S_HEAD;
          S_HEAD:  state[in_vc] <= in_tail ? S_IDLE : S_BODY;
          S_BODY:  state[in_vc] <= in_tail ? S_IDLE : S_BODY;
          default: state[in_vc] <= S_IDLE;
        endcase
      end
      if (push) wr_ptr <= wr_ptr + fifo_ptr_bits'(1);
      if (pop)  rd_ptr <= rd_ptr + fifo_ptr_bits'(1);
      if (push && !pop)      q_cnt <= q_cnt + QW'(1);
      else if (pop && !push) q_cnt <= q_cnt - QW'(1);
      if (drop) drop_count <= sat_inc16(drop_count);
    end
  end

  // Data registers carry no reset; they are qualified by FSM state and FIFO count.
  always_ff @(posedge clk) begin
    if (accept)
      flit_buf[in_vc][int'(phit_cnt[in_vc]) * phit_size +: phit_size] <= indata;
    if (flit_done) begin
      case (state[in_vc])
        S_IDLE: begin
          src_r[in_vc]  <= flit_c[SRC +: addr_length];
          land_r[in_vc] <= timer;
          len_r[in_vc]  <= 16'd1;
        end
        S_HEAD: begin
          tof_r[in_vc] <= head_tof;
          len_r[in_vc] <= 16'd2;
        end
        default: len_r[in_vc] <= sat_inc16(len_r[in_vc]);
      endcase
    end
    if (push) begin
      q_vc[wr_ptr]  <= in_vc;
      q_src[wr_ptr] <= rec_src;
      q_len[wr_ptr] <= rec_len;
      q_tof[wr_ptr] <= rec_tof;
    end
  end

`ifdef PACKET_CONSUMER_STATS_EN
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      pkt_count <= '0;
      tof_max   <= '0;
    end else if (emit) begin
      pkt_count <= pkt_count + 32'd1;
      if (rec_tof > tof_max) tof_max <= rec_tof;
    end
  end
`endif

endmodule

// File: tb/tb_packet_consumer_mc.sv
// Bench for packet_consumer_mc: instance A uses one phit per flit, instance B
// uses two phits per flit (64-bit flits, so full 64-bit stamps fit).
module tb_packet_consumer_mc;

  logic        clk = 1'b0;
  logic        rs;
  logic [63:0] timer;

  logic        a_en, a_in_new, a_in_tail, a_out_ready, a_out_valid;
  logic [1:0]  a_in_vc, a_out_vc;
  logic [31:0] a_indata, a_out_tof;
  logic [7:0]  a_out_src;
  logic [15:0] a_out_len, a_drop;

  logic        b_en, b_in_new, b_in_tail, b_out_ready, b_out_valid;
  logic [1:0]  b_in_vc, b_out_vc;
  logic [31:0] b_indata, b_out_tof;
  logic [7:0]  b_out_src;
  logic [15:0] b_out_len, b_drop;

`ifdef PACKET_CONSUMER_STATS_EN
  logic [31:0] a_pkt_count, a_tof_max, b_pkt_count, b_tof_max;
`endif

  int compared = 0;
  int failed   = 0;
  logic [58:0] got, exp;

  always #5 clk = ~clk;

  packet_consumer_mc u_a (
    .clk(clk), .rs(rs), .en(a_en), .in_new(a_in_new), .in_vc(a_in_vc),
    .indata(a_indata), .in_tail(a_in_tail), .timer(timer),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vc(a_out_vc),
    .out_source_addr(a_out_src), .out_packet_length(a_out_len),
    .out_time_of_flight(a_out_tof),
`ifdef PACKET_CONSUMER_STATS_EN
    .pkt_count(a_pkt_count), .tof_max(a_tof_max),
`endif
    .drop_count(a_drop)
  );

  packet_consumer_mc #(.flit_size(2), .floorplusone_log2_flit_size(2)) u_b (
    .clk(clk), .rs(rs), .en(b_en), .in_new(b_in_new), .in_vc(b_in_vc),
    .indata(b_indata), .in_tail(b_in_tail), .timer(timer),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vc(b_out_vc),
    .out_source_addr(b_out_src), .out_packet_length(b_out_len),
    .out_time_of_flight(b_out_tof),
`ifdef PACKET_CONSUMER_STATS_EN
    .pkt_count(b_pkt_count), .tof_max(b_tof_max),
`endif
    .drop_count(b_drop)
  );

  function automatic logic [58:0] a_rec();
    return {a_out_valid, a_out_vc, a_out_src, a_out_len, a_out_tof};
  endfunction

  function automatic logic [58:0] b_rec();
    return {b_out_valid, b_out_vc, b_out_src, b_out_len, b_out_tof};
  endfunction

  task automatic a_phit(input logic [1:0] vc, input logic [31:0] d, input logic tl,
                        input logic rdy);
    @(negedge clk);
    a_in_new = 1'b1; a_in_vc = vc; a_indata = d; a_in_tail = tl; a_out_ready = rdy;
    @(posedge clk); #1;
    a_in_new = 1'b0; a_in_tail = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic b_phit(input logic [1:0] vc, input logic [31:0] d, input logic tl);
    @(negedge clk);
    b_in_new = 1'b1; b_in_vc = vc; b_indata = d; b_in_tail = tl;
    @(posedge clk); #1;
    b_in_new = 1'b0; b_in_tail = 1'b0;
  endtask

  task automatic a_pop();
    @(negedge clk); a_out_ready = 1'b1;
    @(posedge clk); #1; a_out_ready = 1'b0;
  endtask

  task automatic b_pop();
    @(negedge clk); b_out_ready = 1'b1;
    @(posedge clk); #1; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (a_rec() !== 59'd0 || a_drop !== 16'd0) begin
      failed++; $display("FAIL reset_a got=%h/%h exp=0", a_rec(), a_drop);
    end
    compared++;
    if (b_rec() !== 59'd0 || b_drop !== 16'd0) begin
      failed++; $display("FAIL reset_b got=%h/%h exp=0", b_rec(), b_drop);
    end
    @(negedge clk); rs = 1'b1;
  endtask

  task automatic test_three_flit();
    timer = 64'd1000;
    a_phit(2'd1, {16'h0, 8'h5A, 8'h11}, 1'b0, 1'b0);
    timer = 64'd1500;
    a_phit(2'd1, 32'd900, 1'b0, 1'b0);
    a_phit(2'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    got = a_rec(); exp = {1'b1, 2'd1, 8'h5A, 16'd3, 32'd100};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL three_flit got=%h exp=%h", got, exp); end
    a_pop();
    compared++;
    if (a_rec() !== 59'd0) begin failed++; $display("FAIL empty_after_pop got=%h exp=0", a_rec()); end
  endtask

  task automatic test_single_flit();
    a_phit(2'd0, {16'h0, 8'h33, 8'h01}, 1'b1, 1'b0);
    got = a_rec(); exp = {1'b1, 2'd0, 8'h33, 16'd1, 32'd0};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL single_flit got=%h exp=%h", got, exp); end
    a_pop();
  endtask

  task automatic test_en_hold();
    timer = 64'd50;
    a_phit(2'd1, {16'h0, 8'h12, 8'h00}, 1'b0, 1'b0);
    a_en = 1'b0;
    a_phit(2'd1, 32'd20, 1'b1, 1'b0);
    a_phit(2'd1, 32'd20, 1'b1, 1'b0);
    compared++;
    if (a_out_valid !== 1'b0) begin failed++; $display("FAIL en_low_ignored got=%b exp=0", a_out_valid); end
    a_en = 1'b1;
    timer = 64'd999;
    a_phit(2'd1, 32'd20, 1'b1, 1'b0);
    got = a_rec(); exp = {1'b1, 2'd1, 8'h12, 16'd2, 32'd30};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL en_resume got=%h exp=%h", got, exp); end
    a_pop();
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 6; i++) a_phit(2'd0, {16'h0, 8'(i), 8'h00}, 1'b1, 1'b0);
    compared++;
    if (a_drop !== 16'd2) begin failed++; $display("FAIL drop_count got=%0d exp=2", a_drop); end
    got = a_rec(); exp = {1'b1, 2'd0, 8'h01, 16'd1, 32'd0};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL full_head got=%h exp=%h", got, exp); end
    a_phit(2'd0, {16'h0, 8'h07, 8'h00}, 1'b1, 1'b1);
    compared++;
    if (a_drop !== 16'd2) begin failed++; $display("FAIL push_pop_full_drop got=%0d exp=2", a_drop); end
    for (int i = 0; i < 4; i++) begin
      got = a_rec();
      exp = {1'b1, 2'd0, (i == 3) ? 8'h07 : 8'(i + 2), 16'd1, 32'd0};
      compared++;
      if (got !== exp) begin failed++; $display("FAIL drain_%0d got=%h exp=%h", i, got, exp); end
      a_pop();
    end
    compared++;
    if (a_out_valid !== 1'b0) begin failed++; $display("FAIL drained_empty got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_interleave();
    logic [31:0] p0 [8];
    logic [31:0] p2 [8];
    p2[0] = 32'h0000_2001; p2[1] = 32'h0; p2[2] = 32'd4000; p2[3] = 32'h0;
    p2[4] = 32'h1111;      p2[5] = 32'h2222; p2[6] = 32'h3333; p2[7] = 32'h4444;
    p0[0] = 32'h0000_1002; p0[1] = 32'h0; p0[2] = 32'd4900; p0[3] = 32'h0;
    p0[4] = 32'h5555;      p0[5] = 32'h6666; p0[6] = 32'h7777; p0[7] = 32'h8888;
    timer = 64'd5000;
    for (int i = 0; i < 8; i++) begin
      b_phit(2'd2, p2[i], i >= 6);
      b_phit(2'd0, p0[i], i >= 6);
    end
    got = b_rec(); exp = {1'b1, 2'd2, 8'h20, 16'd4, 32'd1000};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL interleave_first got=%h exp=%h", got, exp); end
    b_pop();
    got = b_rec(); exp = {1'b1, 2'd0, 8'h10, 16'd4, 32'd100};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL interleave_second got=%h exp=%h", got, exp); end
    b_pop();
  endtask

  task automatic test_tof_wrap();
    timer = 64'd5;
    b_phit(2'd1, {16'h0, 8'h31, 8'h00}, 1'b0);
    b_phit(2'd1, 32'h0, 1'b0);
    b_phit(2'd1, 32'hFFFF_FFF6, 1'b1);
    b_phit(2'd1, 32'hFFFF_FFFF, 1'b1);
    got = b_rec(); exp = {1'b1, 2'd1, 8'h31, 16'd2, 32'd15};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL tof_wrap got=%h exp=%h", got, exp); end
    b_pop();
    timer = 64'h2_0000_0064;
    b_phit(2'd1, {16'h0, 8'h32, 8'h00}, 1'b0);
    b_phit(2'd1, 32'h0, 1'b0);
    b_phit(2'd1, 32'd100, 1'b1);
    b_phit(2'd1, 32'h0, 1'b1);
    got = b_rec(); exp = {1'b1, 2'd1, 8'h32, 16'd2, 32'hFFFF_FFFF};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL tof_saturate got=%h exp=%h", got, exp); end
    b_pop();
  endtask

  task automatic test_reset_mid();
    a_phit(2'd0, {16'h0, 8'h44, 8'h00}, 1'b1, 1'b0);
    a_phit(2'd3, {16'h0, 8'h77, 8'h00}, 1'b0, 1'b0);
    a_phit(2'd3, 32'd10, 1'b0, 1'b0);
    @(negedge clk); rs = 1'b0;
    #1;
    compared++;
    if (a_rec() !== 59'd0 || a_drop !== 16'd0) begin
      failed++; $display("FAIL reset_async got=%h/%h exp=0", a_rec(), a_drop);
    end
    @(negedge clk); rs = 1'b1;
    timer = 64'd300;
    a_phit(2'd3, {16'h0, 8'h66, 8'h00}, 1'b0, 1'b0);
    a_phit(2'd3, 32'd250, 1'b1, 1'b0);
    got = a_rec(); exp = {1'b1, 2'd3, 8'h66, 16'd2, 32'd50};
    compared++;
    if (got !== exp) begin failed++; $display("FAIL after_reset got=%h exp=%h", got, exp); end
    a_pop();
  endtask

  initial begin
    rs = 1'b0; timer = '0;
    a_en = 1'b1; a_in_new = 1'b0; a_in_vc = '0; a_indata = '0; a_in_tail = 1'b0; a_out_ready = 1'b0;
    b_en = 1'b1; b_in_new = 1'b0; b_in_vc = '0; b_indata = '0; b_in_tail = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_three_flit();
    test_single_flit();
    test_en_hold();
    test_fifo_full();
    test_interleave();
    test_tof_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
